keccak_round_ctrl: RTL and testbench
====================================

# keccak_round_ctrl

Sequencer for the serialized Keccak-f permutation datapath. After a start request it loads the state, then steps through every round and every 8-bit slice within each round, driving the 5-bit round index that selects the round constant from the round-constant multiplexer. It reports completion with a done/ready handshake. It sits between the sponge/absorb logic, which issues start, and the permutation datapath plus the round-constant selector.

## Interface
- NUM_ROUNDS, 24, rounds per permutation; must satisfy 1 ≤ NUM_ROUNDS ≤ 2^SEL_W
- SLICES, 8, clock cycles (8-bit slices) per round; ≥ 1
- SEL_W, 5, round-index width
- SLICE_W, 3, slice-index width; 2^SLICE_W ≥ SLICES
- clk  in  1  single clock, all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request a permutation; sampled only in IDLE
- abort  in  1  cancel any in-flight permutation; highest priority after reset
- out_ready  in  1  consumer accepts result while done=1
- load_en  out  1  datapath loads input state (one cycle)
- round_en  out  1  datapath processes the slice selected by slice_idx for round round_sel
- round_sel  out  SEL_W  round index to round-constant mux
- slice_idx  out  SLICE_W  current slice within the round
- round_last  out  1  round_en=1 and round_sel=NUM_ROUNDS-1
- busy  out  1  state ≠ IDLE
- done  out  1  result valid, held until out_ready

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. All outputs are registered or decoded from registered state, with no combinational path from inputs to outputs.
- IDLE: start=1 → LOAD. Otherwise stay.
- LOAD: load_en=1 for exactly one cycle. Round and slice counters are 0. Next state is RUN.
- RUN: round_en=1 every cycle.
  - slice_idx increments each cycle.
  - When slice_idx=SLICES-1: slice_idx←0 and round_sel increments.
  - When round_sel=NUM_ROUNDS-1 and slice_idx=SLICES-1: next state is DONE and both counters clear.
- DONE: done=1. out_ready=1 → IDLE next edge. Otherwise hold.
- start outside IDLE is ignored and not queued. start and out_ready high together in DONE → IDLE only; a new start is needed in IDLE.
- abort=1 in LOAD/RUN/DONE → IDLE next edge with counters cleared and no done pulse. abort in IDLE has no effect. abort overrides start, out_ready and counter advance in the same cycle.
- round_sel and slice_idx read 0 in IDLE, LOAD and DONE.
- Reset (any time, including mid-RUN): immediately IDLE.
  - All outputs 0.
  - Counters 0.

## Timing
- start sampled high at edge k:
  - load_en is high in the cycle after edge k.
  - round_en is high after edges k+1 … k+NUM_ROUNDS·SLICES (192 cycles at defaults).
  - done rises after edge k+NUM_ROUNDS·SLICES+1 (k+193).
- round_sel holds each value for SLICES consecutive cycles. round_sel=r while slice_idx runs 0…SLICES-1.
- round_last is high for the final SLICES cycles of RUN.
- Minimum start-to-start period: NUM_ROUNDS·SLICES+3 cycles (LOAD, RUN, one DONE cycle, one IDLE cycle).
- out_ready held high continuously: done is a one-cycle pulse.

## Structure
- Shared package keccak_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE)
  - KECCAK_NUM_ROUNDS=24
  - KECCAK_SEL_W=5
  - KECCAK_SLICES=8
- Also shared with the datapath and round-constant selector: the round-index type logic [SEL_W-1:0].
- Sub-module keccak_round_counter is a natural split:
  - nested slice/round counter with clear, enable and a wrap flag (last slice of last round)
  - the FSM instantiates it and consumes the wrap flag.

## Test plan
- Reset then idle: rst_n low mid-cycle → all outputs 0 asynchronously. Release; 10 idle cycles with start=0 → busy=0, done=0.
- Nominal run: start pulse at edge k → load_en only after k. round_sel steps 0…23, each for 8 cycles, with slice_idx 0…7. round_last over the last 8 cycles. done after k+193. out_ready at done+3 → busy=0 next cycle.
- Done hold and overlap:
  - out_ready=0 for 20 cycles after done → done stays 1 and round_sel=0.
  - Then start=1 together with out_ready=1 → IDLE and no LOAD on that edge.
  - start next cycle → LOAD.
- Abort: abort at round_sel=11, slice_idx=5 → IDLE next edge, no done ever. start afterwards → full 192-cycle run from round 0.
- Ignored start and mid-run reset:
  - start held high through RUN → exactly one permutation per IDLE visit.
  - rst_n asserted at round_sel=17 → outputs 0 immediately; counters restart from 0 on next start.
- Parameter variant NUM_ROUNDS=18, SLICES=1 → round_en for 18 cycles, round_sel 0…17, done after k+19.

Source files
------------

// File: rtl/keccak_ctrl_pkg.sv
// rtl/keccak_ctrl_pkg.sv - shared types and defaults for the Keccak round sequencer
package keccak_ctrl_pkg;

  localparam int KECCAK_NUM_ROUNDS = 24;
  localparam int KECCAK_SEL_W      = 5;
  localparam int KECCAK_SLICES     = 8;
  localparam int KECCAK_SLICE_W    = 3;

  // Round index as seen by the datapath and the round-constant selector
  typedef logic [KECCAK_SEL_W-1:0] round_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/keccak_round_counter.sv
// rtl/keccak_round_counter.sv - nested slice/round counter with wrap flag
module keccak_round_counter #(
  parameter int NUM_ROUNDS = 24,
  parameter int SLICES     = 8,
  parameter int SEL_W      = 5,
  parameter int SLICE_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  output logic [SEL_W-1:0]   round_q,
  output logic [SLICE_W-1:0] slice_q,
  output logic               wrap
);

  localparam logic [SEL_W-1:0]   LAST_ROUND = SEL_W'(NUM_ROUNDS - 1);
  localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(SLICES - 1);

  logic [SEL_W-1:0]   round_d;
  logic [SLICE_W-1:0] slice_d;
  logic               slice_last;

  assign slice_last = (slice_q == LAST_SLICE);
  // Wrap marks the final slice of the final round, independent of en
  assign wrap       = slice_last && (round_q == LAST_ROUND);

  always_comb begin
    round_d = round_q;
    slice_d = slice_q;
    if (clr) begin
      round_d = '0;
      slice_d = '0;
    end else if (en) begin
      if (slice_last) begin
        slice_d = '0;
        round_d = wrap ? '0 : round_q + 1'b1;
      end else begin
        slice_d = slice_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_q <= '0;
      slice_q <= '0;
    end else begin
      round_q <= round_d;
      slice_q <= slice_d;
    end
  end

endmodule

// File: rtl/keccak_round_ctrl.sv
// rtl/keccak_round_ctrl.sv - sequencer for the serialized Keccak-f permutation datapath
module keccak_round_ctrl
  import keccak_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = KECCAK_NUM_ROUNDS,
  parameter int SLICES     = KECCAK_SLICES,
  parameter int SEL_W      = KECCAK_SEL_W,
  parameter int SLICE_W    = KECCAK_SLICE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               out_ready,
  output logic               load_en,
  output logic               round_en,
  output logic [SEL_W-1:0]   round_sel,
  output logic [SLICE_W-1:0] slice_idx,
  output logic               round_last,
  output logic               busy,
  output logic               done
);

  localparam logic [SEL_W-1:0] LAST_ROUND = SEL_W'(NUM_ROUNDS - 1);

  ctrl_state_e state_q, state_d;
  logic load_en_q, load_en_d;
  logic round_en_q, round_en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic               cnt_clr;
  logic               cnt_en;
  logic               cnt_wrap;
  logic [SEL_W-1:0]   round_q;
  logic [SLICE_W-1:0] slice_q;

  // Counters only move in RUN; anywhere else they are held at zero
  assign cnt_en  = (state_q == RUN);
  assign cnt_clr = abort || (state_q != RUN);

  keccak_round_counter #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .SLICES     (SLICES),
    .SEL_W      (SEL_W),
    .SLICE_W    (SLICE_W)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .round_q (round_q),
    .slice_q (slice_q),
    .wrap    (cnt_wrap)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (cnt_wrap) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;

    // Outputs are registered against the next state so they line up with it
    load_en_d  = (state_d == LOAD);
    round_en_d = (state_d == RUN);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      load_en_q  <= 1'b0;
      round_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_en_q  <= load_en_d;
      round_en_q <= round_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign load_en    = load_en_q;
  assign round_en   = round_en_q;
  assign round_sel  = round_q;
  assign slice_idx  = slice_q;
  assign round_last = round_en_q && (round_q == LAST_ROUND);
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// tb/tb_keccak_round_ctrl.sv - self-checking bench for keccak_round_ctrl
module tb_keccak_round_ctrl;

  localparam int NR  = 24;
  localparam int NS  = 8;
  localparam int D   = NR * NS + 1;
  localparam int VNR = 18;
  localparam int VNS = 1;
  localparam int VD  = VNR * VNS + 1;

  typedef struct packed {
    logic       load;
    logic       ren;
    logic [4:0] rsel;
    logic [2:0] sidx;
    logic       rlast;
    logic       busy;
    logic       done;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic start_v = 1'b0, abort_v = 1'b0, out_ready_v = 1'b0;

  logic       load_en, round_en, round_last, busy, done;
  logic [4:0] round_sel;
  logic [2:0] slice_idx;
  logic       load_en_v, round_en_v, round_last_v, busy_v, done_v;
  logic [4:0] round_sel_v;
  logic [2:0] slice_idx_v;

  obs_t obs, obs_v;
  assign obs   = {load_en, round_en, round_sel, slice_idx, round_last, busy, done};
  assign obs_v = {load_en_v, round_en_v, round_sel_v, slice_idx_v, round_last_v, busy_v, done_v};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  keccak_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .out_ready(out_ready),
    .load_en(load_en), .round_en(round_en), .round_sel(round_sel), .slice_idx(slice_idx),
    .round_last(round_last), .busy(busy), .done(done)
  );

  keccak_round_ctrl #(.NUM_ROUNDS(VNR), .SLICES(VNS)) dut_v (
    .clk(clk), .rst_n(rst_n), .start(start_v), .abort(abort_v), .out_ready(out_ready_v),
    .load_en(load_en_v), .round_en(round_en_v), .round_sel(round_sel_v), .slice_idx(slice_idx_v),
    .round_last(round_last_v), .busy(busy_v), .done(done_v)
  );

  // Expected outputs t cycles after the edge that sampled start (DONE held while t > nr*ns)
  function automatic obs_t model(int t, int nr, int ns);
    obs_t e;
    e = '0;
    e.busy = 1'b1;
    if (t == 0) begin
      e.load = 1'b1;
    end else if (t <= nr * ns) begin
      e.ren   = 1'b1;
      e.rsel  = 5'((t - 1) / ns);
      e.sidx  = 3'((t - 1) % ns);
      e.rlast = (((t - 1) / ns) == nr - 1);
    end else begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #7;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== obs_t'('0)) begin
      n_fail++;
      $display("FAIL reset_async got=%h exp=%h", obs, obs_t'('0));
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (obs.busy !== 1'b0 || obs.done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got=%h exp busy=0 done=0", i, obs);
      end
    end
  endtask

  // Full permutation checked cycle by cycle; out_ready rises w cycles after done
  task automatic test_full_run(input int w);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t <= D + w; t++) begin
      n_checks++;
      if (obs !== model(t, NR, NS)) begin
        n_fail++;
        $display("FAIL full_run t=%0d got=%h exp=%h", t, obs, model(t, NR, NS));
      end
      if (t == D + w) out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    n_checks++;
    if (obs !== obs_t'('0)) begin
      n_fail++;
      $display("FAIL full_run_accept got=%h exp=%h", obs, obs_t'('0));
    end
  endtask

  task automatic test_nominal();
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 4)) step();
      test_full_run((i == 0) ? 2 : int'($urandom_range(0, 4)));
    end
  endtask

  task automatic test_done_hold();
    int cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (obs.done !== 1'b1 && cyc < 400) begin
      step();
      cyc++;
    end
    n_checks++;
    if (cyc != D) begin
      n_fail++;
      $display("FAIL done_latency got=%0d exp=%0d", cyc, D);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (obs !== model(D, NR, NS)) begin
        n_fail++;
        $display("FAIL done_hold cyc=%0d got=%h exp=%h", i, obs, model(D, NR, NS));
      end
    end
    start = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (obs !== obs_t'('0)) begin
      n_fail++;
      $display("FAIL overlap_idle got=%h exp=%h", obs, obs_t'('0));
    end
    step();
    start = 1'b0;
    for (int t = 0; t <= D; t++) begin
      n_checks++;
      if (obs !== model(t, NR, NS)) begin
        n_fail++;
        $display("FAIL overlap_run t=%0d got=%h exp=%h", t, obs, model(t, NR, NS));
      end
      if (t == D) out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_abort(input int at_t);
    bit saw_done;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t <= at_t; t++) begin
      n_checks++;
      if (obs !== model(t, NR, NS)) begin
        n_fail++;
        $display("FAIL abort_pre t=%0d got=%h exp=%h", t, obs, model(t, NR, NS));
      end
      if (t == at_t) begin
        abort = 1'b1;
        out_ready = $urandom_range(0, 1);
        start = $urandom_range(0, 1);
      end
      step();
    end
    abort = 1'b0;
    out_ready = 1'b0;
    start = 1'b0;
    n_checks++;
    if (obs !== obs_t'('0)) begin
      n_fail++;
      $display("FAIL abort_idle at=%0d got=%h exp=%h", at_t, obs, obs_t'('0));
    end
    saw_done = 1'b0;
    for (int i = 0; i < D + 4; i++) begin
      step();
      if (obs.done === 1'b1 || obs.busy === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL abort_no_done at=%0d got=1 exp=0", at_t);
    end
    test_full_run($urandom_range(0, 3));
  endtask

  task automatic test_ignored_start();
    int p;
    p = D + 2;
    start = 1'b1;
    out_ready = 1'b1;
    step();
    for (int t = 0; t < 2 * p; t++) begin
      obs_t e;
      e = ((t % p) <= D) ? model(t % p, NR, NS) : obs_t'('0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL held_start t=%0d got=%h exp=%h", t, obs, e);
      end
      if (t == 2 * p - 2) start = 1'b0;
      step();
    end
    out_ready = 1'b0;
    n_checks++;
    if (obs !== obs_t'('0)) begin
      n_fail++;
      $display("FAIL held_start_end got=%h exp=%h", obs, obs_t'('0));
    end
  endtask

  task automatic test_midrun_reset();
    int at_t;
    at_t = 1 + 17 * NS + int'($urandom_range(0, NS - 1));
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < at_t; t++) step();
    n_checks++;
    if (obs !== model(at_t, NR, NS)) begin
      n_fail++;
      $display("FAIL pre_reset t=%0d got=%h exp=%h", at_t, obs, model(at_t, NR, NS));
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== obs_t'('0)) begin
      n_fail++;
      $display("FAIL midrun_reset got=%h exp=%h", obs, obs_t'('0));
    end
    step();
    rst_n = 1'b1;
    step();
    test_full_run(1);
  endtask

  task automatic test_variant();
    start_v = 1'b1;
    step();
    start_v = 1'b0;
    for (int t = 0; t <= VD; t++) begin
      n_checks++;
      if (obs_v !== model(t, VNR, VNS)) begin
        n_fail++;
        $display("FAIL variant t=%0d got=%h exp=%h", t, obs_v, model(t, VNR, VNS));
      end
      if (t == VD) out_ready_v = 1'b1;
      step();
    end
    out_ready_v = 1'b0;
    n_checks++;
    if (obs_v !== obs_t'('0)) begin
      n_fail++;
      $display("FAIL variant_accept got=%h exp=%h", obs_v, obs_t'('0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_done_hold();
    test_abort(1 + 11 * NS + 5);
    test_abort(0);
    test_abort(D + 2);
    test_abort($urandom_range(0, D + 3));
    test_ignored_start();
    test_midrun_reset();
    test_variant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
